// File: rtl/linear_interp_pkg.sv
// Shared definitions for the inverse linear interpolator: FSM state
// encoding, derived operand widths and the divide-iteration count.
package linear_interp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        DIV,
        FIX,
        DONE
    } state_t;

    localparam int LI_DATA_WIDTH = 16;

    // Width of a signed difference of two unsigned operands
    function automatic int delta_width(input int dw);
        return dw + 1;
    endfunction

    // Width of the signed product and of the signed result sum
    function automatic int prod_width(input int dw);
        return 2 * dw + 2;
    endfunction

    // Width of the unsigned dividend magnitude and of the quotient
    function automatic int quot_width(input int dw);
        return 2 * dw;
    endfunction

    // One quotient bit per cycle, so one iteration per quotient bit
    function automatic int div_iterations(input int dw);
        return quot_width(dw);
    endfunction

    localparam int DELTA_W   = delta_width(LI_DATA_WIDTH);
    localparam int PROD_W    = prod_width(LI_DATA_WIDTH);
    localparam int QUOT_W    = quot_width(LI_DATA_WIDTH);
    localparam int DIV_ITERS = div_iterations(LI_DATA_WIDTH);

endpackage

// File: rtl/seq_restoring_divider.sv
// Unsigned sequential restoring divider, one quotient bit per cycle,
// MSB first. The dividend register shifts left and collects quotient bits
// at its bottom, so after DIVIDEND_W steps it holds the quotient.
// 'done' is high during the cycle whose closing edge writes the last bit.
module seq_restoring_divider #(
    parameter int DIVIDEND_W = 32,
    parameter int DIVISOR_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient
);

    localparam int CNT_W = $clog2(DIVIDEND_W);

    logic [DIVIDEND_W-1:0] dq_reg;
    logic [DIVISOR_W-1:0]  rem_reg;
    logic [DIVISOR_W-1:0]  divisor_reg;
    logic [CNT_W-1:0]      count;
    logic [DIVISOR_W:0]    shifted;
    logic [DIVISOR_W:0]    diff;
    logic                  fits;

    // Trial subtraction of the divisor from the shifted partial remainder
    always_comb begin
        shifted = {rem_reg, dq_reg[DIVIDEND_W-1]};
        diff    = shifted - {1'b0, divisor_reg};
        fits    = ~diff[DIVISOR_W];
    end

    assign done     = busy && (count == CNT_W'(DIVIDEND_W - 1));
    assign quotient = dq_reg;

    // Load on start, then restore-or-keep one quotient bit per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dq_reg      <= '0;
            rem_reg     <= '0;
            divisor_reg <= '0;
            count       <= '0;
            busy        <= 1'b0;
        end else if (start) begin
            dq_reg      <= dividend;
            rem_reg     <= '0;
            divisor_reg <= divisor;
            count       <= '0;
            busy        <= 1'b1;
        end else if (busy) begin
            rem_reg <= fits ? diff[DIVISOR_W-1:0] : shifted[DIVISOR_W-1:0];
            dq_reg  <= {dq_reg[DIVIDEND_W-2:0], fits};
            count   <= count + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/linear_inverse_interp.sv
// Sequential inverse linear interpolator:
//   x = x0 + ((y - y0) * (x1 - x0)) / (y1 - y0), quotient truncated toward zero.
// Operands are taken apart into magnitude and sign so the divider only ever
// sees unsigned values; the sign is reapplied to the quotient before adding x0.
// Optional build macro LINEAR_INVERSE_INTERP_SAT_EN: saturate x on overflow
// instead of wrapping to DATA_WIDTH bits.
module linear_inverse_interp
    import linear_interp_pkg::*;
#(
    parameter int DATA_WIDTH = LI_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] x0,
    input  logic [DATA_WIDTH-1:0] y0,
    input  logic [DATA_WIDTH-1:0] x1,
    input  logic [DATA_WIDTH-1:0] y1,
    input  logic [DATA_WIDTH-1:0] y,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] x,
    output logic                  div_by_zero,
    output logic                  overflow
);

    localparam int DW = DATA_WIDTH;
    localparam int PW = prod_width(DATA_WIDTH);
    localparam int QW = quot_width(DATA_WIDTH);

    state_t state, next_state;

    logic [DW-1:0] x0_q, y0_q, x1_q, y1_q, y_q;
    logic          sign_q;
    logic          dbz_q;

    logic          dx_neg, dy_neg, dn_neg;
    logic [DW-1:0] dx_mag, dy_mag, dn_mag;
    logic [QW-1:0] num_mag;
    logic          dy_zero;

    logic          div_start, div_busy, div_done;
    logic [QW-1:0] quotient;

    logic [PW-1:0] q_ext, q_val, r;
    logic          r_neg, r_high;
    logic [DW-1:0] x_next;

    // Differences as sign + magnitude; each magnitude fits DW bits, so the
    // product of magnitudes is |num| and the sign is the XOR of all three
    always_comb begin
        dx_neg  = x1_q < x0_q;
        dy_neg  = y1_q < y0_q;
        dn_neg  = y_q < y0_q;
        dx_mag  = dx_neg ? (x0_q - x1_q) : (x1_q - x0_q);
        dy_mag  = dy_neg ? (y0_q - y1_q) : (y1_q - y0_q);
        dn_mag  = dn_neg ? (y0_q - y_q) : (y_q - y0_q);
        num_mag = QW'(dn_mag) * QW'(dx_mag);
        dy_zero = (y1_q == y0_q);
    end

    assign div_start = (state == PREP) && !dy_zero;

    seq_restoring_divider #(
        .DIVIDEND_W(QW),
        .DIVISOR_W (DW)
    ) u_divider (
        .clk     (clk),
        .rst     (rst),
        .start   (div_start),
        .dividend(num_mag),
        .divisor (dy_mag),
        .busy    (div_busy),
        .done    (div_done),
        .quotient(quotient)
    );

    // Reapply the sign, add x0 at full signed width and classify the range
    always_comb begin
        q_ext  = dbz_q ? '0 : PW'(quotient);
        q_val  = sign_q ? (~q_ext + 1'b1) : q_ext;
        r      = PW'(x0_q) + q_val;
        r_neg  = r[PW-1];
        r_high = !r_neg && (|r[PW-2:DW]);
`ifdef LINEAR_INVERSE_INTERP_SAT_EN
        x_next = r_neg ? '0 : (r_high ? '1 : r[DW-1:0]);
`else
        x_next = r[DW-1:0];
`endif
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; leaving DIV if the divider is idle avoids a lockup
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (in_valid)              next_state = PREP;
            PREP: next_state = dy_zero ? FIX : DIV;
            DIV:  if (div_done || !div_busy) next_state = FIX;
            FIX:  next_state = DONE;
            DONE: if (out_ready)             next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Operand capture, sign/zero latching and registered result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x0_q        <= '0;
            y0_q        <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
            y_q         <= '0;
            sign_q      <= 1'b0;
            dbz_q       <= 1'b0;
            x           <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x0_q <= x0;
                        y0_q <= y0;
                        x1_q <= x1;
                        y1_q <= y1;
                        y_q  <= y;
                    end
                end
                PREP: begin
                    sign_q <= dn_neg ^ dx_neg ^ dy_neg;
                    dbz_q  <= dy_zero;
                end
                FIX: begin
                    x           <= x_next;
                    div_by_zero <= dbz_q;
                    overflow    <= r_neg || r_high;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_linear_inverse_interp.sv
// Directed self-checking bench for linear_inverse_interp (DATA_WIDTH=16).
// Expected values are hand-computed from the interpolation formula.
module tb_linear_inverse_interp;

    localparam int DW = 16;
    localparam int MAX_WAIT = 200;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0, y = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] x;
    logic          div_by_zero;
    logic          overflow;

    int num_checks = 0;
    int num_fails  = 0;
    int latency;

    linear_inverse_interp #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x0         (x0),
        .y0         (y0),
        .x1         (x1),
        .y1         (y1),
        .y          (y),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .x          (x),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Present one operand set, wait for the accept edge, then count edges
    // until out_valid is seen (sampled 1 time unit after each edge)
    task automatic applyStimulus(input logic [DW-1:0] a_x0, input logic [DW-1:0] a_y0,
                                 input logic [DW-1:0] a_x1, input logic [DW-1:0] a_y1,
                                 input logic [DW-1:0] a_y, output int cycles);
        int waited;
        waited = 0;
        while (!in_ready && waited < MAX_WAIT) begin
            @(posedge clk);
            #1;
            waited++;
        end
        x0 = a_x0; y0 = a_y0; x1 = a_x1; y1 = a_y1; y = a_y;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cycles = 0;
        while (!out_valid && cycles < MAX_WAIT) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    // Full transaction: stimulus, result checks, then the output handshake
    task automatic runCase(input string tag,
                           input logic [DW-1:0] a_x0, input logic [DW-1:0] a_y0,
                           input logic [DW-1:0] a_x1, input logic [DW-1:0] a_y1,
                           input logic [DW-1:0] a_y,
                           input logic [DW-1:0] exp_x, input logic exp_dbz,
                           input logic exp_ovf, input int exp_lat);
        applyStimulus(a_x0, a_y0, a_x1, a_y1, a_y, latency);
        checkOutput({tag, " latency"}, latency, exp_lat);
        checkOutput({tag, " out_valid"}, {31'd0, out_valid}, 1);
        checkOutput({tag, " x"}, {16'd0, x}, {16'd0, exp_x});
        checkOutput({tag, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, exp_dbz});
        checkOutput({tag, " overflow"}, {31'd0, overflow}, {31'd0, exp_ovf});
        checkOutput({tag, " in_ready busy"}, {31'd0, in_ready}, 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, " out_valid released"}, {31'd0, out_valid}, 0);
        checkOutput({tag, " in_ready released"}, {31'd0, in_ready}, 1);
    endtask

    logic [DW-1:0] exp_ovf_x;
    logic [DW-1:0] held_x;

    initial begin
`ifdef LINEAR_INVERSE_INTERP_SAT_EN
        exp_ovf_x = 16'd65535;
`else
        exp_ovf_x = 16'd534;
`endif
        // Reset values while reset is held
        #12;
        checkOutput("reset in_ready", {31'd0, in_ready}, 1);
        checkOutput("reset out_valid", {31'd0, out_valid}, 0);
        checkOutput("reset x", {16'd0, x}, 0);
        checkOutput("reset div_by_zero", {31'd0, div_by_zero}, 0);
        checkOutput("reset overflow", {31'd0, overflow}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        runCase("rising",   16'd0,     16'd0,    16'd100,   16'd200, 16'd50,  16'd25,  1'b0, 1'b0, 34);
        runCase("falling",  16'd10,    16'd1000, 16'd20,    16'd0,   16'd500, 16'd15,  1'b0, 1'b0, 34);
        runCase("trunc pos", 16'd0,    16'd0,    16'd10,    16'd3,   16'd2,   16'd6,   1'b0, 1'b0, 34);
        runCase("trunc neg", 16'd100,  16'd0,    16'd90,    16'd3,   16'd2,   16'd94,  1'b0, 1'b0, 34);
        runCase("dbz",      16'd42,    16'd7,    16'd1234,  16'd7,   16'd9,   16'd42,  1'b1, 1'b0, 2);
        runCase("overflow", 16'd65000, 16'd0,    16'd65535, 16'd1,   16'd2,   exp_ovf_x, 1'b0, 1'b1, 34);
        runCase("underflow", 16'd5,    16'd0,    16'd0,     16'd1,   16'd10,
`ifdef LINEAR_INVERSE_INTERP_SAT_EN
                16'd0,
`else
                16'd65491,
`endif
                1'b0, 1'b1, 34);

        // Backpressure: result held stable with out_ready low
        applyStimulus(16'd0, 16'd0, 16'd100, 16'd200, 16'd150, latency);
        checkOutput("bp latency", latency, 34);
        held_x = x;
        checkOutput("bp x", {16'd0, held_x}, 75);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp hold x", {16'd0, x}, 75);
            checkOutput("bp hold out_valid", {31'd0, out_valid}, 1);
            checkOutput("bp hold in_ready", {31'd0, in_ready}, 0);
            checkOutput("bp hold flags", {30'd0, div_by_zero, overflow}, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("bp released in_ready", {31'd0, in_ready}, 1);

        // Reset in the middle of a division
        x0 = 16'd0; y0 = 16'd0; x1 = 16'd100; y1 = 16'd200; y = 16'd50;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("midrst out_valid", {31'd0, out_valid}, 0);
        checkOutput("midrst in_ready", {31'd0, in_ready}, 1);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midrst idle", {31'd0, in_ready}, 1);
        runCase("after rst", 16'd1000, 16'd100, 16'd2000, 16'd300, 16'd250, 16'd1750, 1'b0, 1'b0, 34);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
